// File: rtl/wall_collision_detector.sv
// Per-frame cushion/corner collision initiator that drives the reflection responder and sequences up to two reflections.
// Define CORNER_CHAMFER_EN to enable chamfered-corner detection (wall codes 4, 6, 8, 10).
module wall_collision_detector #(
    parameter int unsigned TABLE_LEFT   = 40,
    parameter int unsigned TABLE_RIGHT  = 600,
    parameter int unsigned TABLE_TOP    = 40,
    parameter int unsigned TABLE_BOTTOM = 440,
    parameter int unsigned BALL_RADIUS  = 8,
    parameter int unsigned CORNER_CUT   = 24
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        frame_valid_in,
    input  logic [10:0] ball_x_in,
    input  logic [9:0]  ball_y_in,
    input  logic [15:0] ball_direction_in,
    input  logic [15:0] helper_result_in,
    output logic [15:0] helper_direction_out,
    output logic [3:0]  wall_direction_out,
    output logic        wall_valid_out,
    output logic [15:0] direction_out,
    output logic        direction_valid_out,
    output logic        busy_out,
    output logic [7:0]  collision_count_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ1,
        S_REQ2,
        S_DONE
    } state_t;

    localparam logic [16:0] LEFT_W   = 17'(TABLE_LEFT);
    localparam logic [16:0] RIGHT_W  = 17'(TABLE_RIGHT);
    localparam logic [16:0] TOP_W    = 17'(TABLE_TOP);
    localparam logic [16:0] BOTTOM_W = 17'(TABLE_BOTTOM);
    localparam logic [16:0] R_W      = 17'(BALL_RADIUS);
`ifdef CORNER_CHAMFER_EN
    localparam logic [16:0] CUT_W    = 17'(CORNER_CUT);
`endif

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [15:0] dir_q, dir_d;
    logic        second_q, second_d;
    logic [3:0]  ycode_q, ycode_d;
    logic [15:0] helper_dir_q, helper_dir_d;
    logic [3:0]  wall_code_q, wall_code_d;
    logic [15:0] dir_out_q, dir_out_d;
    logic [7:0]  count_q, count_d;

    logic [16:0] x17, y17, d17;
    logic        hit_right, hit_left, hit_bottom, hit_top;
    logic        x_hit, y_hit;
    logic [3:0]  x_code, y_code;
    logic [15:0] result_red;
    logic [7:0]  count_inc;

    // Contact and approach tests on the latched frame; everything is 17-bit unsigned.
    always_comb begin
        x17 = {6'b0, x_q};
        y17 = {7'b0, y_q};
        d17 = {1'b0, dir_q};

        hit_right  = (x17 + R_W >= RIGHT_W)  && (d17 < 17'd90 || d17 > 17'd270);
        hit_left   = (x17 <= LEFT_W + R_W)   && (d17 > 17'd90 && d17 < 17'd270);
        hit_bottom = (y17 + R_W >= BOTTOM_W) && (d17 > 17'd0 && d17 < 17'd180);
        hit_top    = (y17 <= TOP_W + R_W)    && (d17 > 17'd180 && d17 < 17'd360);

        x_hit  = hit_right || hit_left;
        x_code = hit_right ? 4'd0 : 4'd2;
        y_hit  = hit_bottom || hit_top;
        y_code = hit_bottom ? 4'd1 : 4'd3;
    end

`ifdef CORNER_CHAMFER_EN
    logic       corner_contact, corner_approach;
    logic [3:0] corner_code;

    // Manhattan distance to each corner, rearranged so no term can go negative.
    always_comb begin
        corner_contact  = 1'b1;
        corner_approach = 1'b0;
        corner_code     = 4'd0;
        if (x17 + y17 + CUT_W + R_W >= RIGHT_W + BOTTOM_W) begin
            corner_code     = 4'd4;
            corner_approach = (d17 < 17'd135) || (d17 > 17'd315);
        end else if (y17 + RIGHT_W <= x17 + TOP_W + CUT_W + R_W) begin
            corner_code     = 4'd6;
            corner_approach = (d17 < 17'd45) || (d17 > 17'd225);
        end else if (x17 + y17 <= LEFT_W + TOP_W + CUT_W + R_W) begin
            corner_code     = 4'd8;
            corner_approach = (d17 > 17'd135) && (d17 < 17'd315);
        end else if (x17 + BOTTOM_W <= y17 + LEFT_W + CUT_W + R_W) begin
            corner_code     = 4'd10;
            corner_approach = (d17 > 17'd45) && (d17 < 17'd225);
        end else begin
            corner_contact  = 1'b0;
        end
    end
`endif

    assign result_red = (helper_result_in >= 16'd360) ? helper_result_in - 16'd360
                                                      : helper_result_in;
    assign count_inc  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    // NOTE: every variable gets its default first so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;
        second_d     = second_q;
        ycode_d      = ycode_q;
        helper_dir_d = helper_dir_q;
        wall_code_d  = wall_code_q;
        dir_out_d    = dir_out_q;
        count_d      = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (frame_valid_in) begin
                    x_d     = ball_x_in;
                    y_d     = ball_y_in;
                    dir_d   = ball_direction_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                second_d     = 1'b0;
                helper_dir_d = dir_q;
                state_d      = S_REQ1;
`ifdef CORNER_CHAMFER_EN
                if (corner_contact) begin
                    if (corner_approach) begin
                        wall_code_d = corner_code;
                    end else begin
                        helper_dir_d = helper_dir_q;
                        dir_out_d    = dir_q;
                        state_d      = S_DONE;
                    end
                end else
`endif
                if (x_hit) begin
                    wall_code_d = x_code;
                    second_d    = y_hit;
                    ycode_d     = y_code;
                end else if (y_hit) begin
                    wall_code_d = y_code;
                end else begin
                    helper_dir_d = helper_dir_q;
                    dir_out_d    = dir_q;
                    state_d      = S_DONE;
                end
            end
            S_REQ1: begin
                count_d = count_inc;
                dir_d   = result_red;
                if (second_q) begin
                    wall_code_d  = ycode_q;
                    helper_dir_d = result_red;
                    state_d      = S_REQ2;
                end else begin
                    dir_out_d = result_red;
                    state_d   = S_DONE;
                end
            end
            S_REQ2: begin
                count_d   = count_inc;
                dir_d     = result_red;
                dir_out_d = result_red;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: every register, including the latched frame, is cleared by reset so a dropped frame leaves nothing behind.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            dir_q        <= '0;
            second_q     <= 1'b0;
            ycode_q      <= '0;
            helper_dir_q <= '0;
            wall_code_q  <= '0;
            dir_out_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_q        <= dir_d;
            second_q     <= second_d;
            ycode_q      <= ycode_d;
            helper_dir_q <= helper_dir_d;
            wall_code_q  <= wall_code_d;
            dir_out_q    <= dir_out_d;
            count_q      <= count_d;
        end
    end

    assign helper_direction_out = helper_dir_q;
    assign wall_direction_out   = wall_code_q;
    assign wall_valid_out       = (state_q == S_REQ1) || (state_q == S_REQ2);
    assign direction_out        = dir_out_q;
    assign direction_valid_out  = (state_q == S_DONE);
    assign busy_out             = (state_q != S_IDLE);
    assign collision_count_out  = count_q;

endmodule
